muxn_pipe_scan: RTL and testbench

//  Parametrised N:1, W-bit data selector built as a tree of 2:1 stages, with optional
//  per-level pipelining, valid tagging and an auto-scan mode that steps through channels.

---
 rtl/muxn_pipe_scan.sv | 175 +++++++++++++++++
 tb/tb_muxn_pipe_scan.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/muxn_pipe_scan.sv
// muxn_pipe_scan: N:1, WIDTH-bit channel selector built as a tree of 2:1 stages.
// Each sample carries its valid bit and channel index with it through the tree.
// The select comes from the host (sel) or from an internal round-robin scanner (mode=1).
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous reset, active-high
//   din       packed channels, channel i at din[i*WIDTH +: WIDTH]
//   sel       manual channel select, used when mode=0
//   mode      0 = manual select, 1 = scan through channels, DWELL cycles on each
//   in_valid  din/select sample is valid this cycle
//   out       selected data, holds its value on bubbles
//   out_valid out carries a new sample this cycle
//   out_ch    channel index that produced out
//   scan_wrap one-cycle pulse after the scanner steps from NUM_IN-1 back to 0
module muxn_pipe_scan #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 4,
    parameter int PIPE   = 1,
    parameter int DWELL  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_IN*WIDTH-1:0]   din,
    input  logic [$clog2(NUM_IN)-1:0] sel,
    input  logic                      mode,
    input  logic                      in_valid,
    output logic [WIDTH-1:0]          out,
    output logic                      out_valid,
    output logic [$clog2(NUM_IN)-1:0] out_ch,
    output logic                      scan_wrap
);
    localparam int SELW = $clog2(NUM_IN);
    localparam int DW   = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam int HALF = NUM_IN / 2;

    typedef logic [WIDTH-1:0] word_t;

    if (NUM_IN < 2 || (NUM_IN & (NUM_IN - 1)) != 0) begin : g_bad_num_in
        $error("muxn_pipe_scan: NUM_IN must be a power of 2 and at least 2");
    end
    if (DWELL < 1) begin : g_bad_dwell
        $error("muxn_pipe_scan: DWELL must be at least 1");
    end

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [SELW-1:0] scan_ch;
    logic [DW-1:0]   dwell_cnt;
    logic [SELW-1:0] esel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_ch   <= '0;
            dwell_cnt <= '0;
            scan_wrap <= 1'b0;
        end else if (!mode) begin
            // Held at zero so that entering scan always starts on channel 0.
            scan_ch   <= '0;
            dwell_cnt <= '0;
            scan_wrap <= 1'b0;
        end else if (dwell_cnt == DW'(DWELL - 1)) begin
            dwell_cnt <= '0;
            scan_ch   <= scan_ch + 1'b1;
            scan_wrap <= (scan_ch == SELW'(NUM_IN - 1));
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
            scan_wrap <= 1'b0;
        end
    end

    assign esel = mode ? scan_ch : sel;

    // ------------------------------------------------------------------
    // Selection tree
    // ------------------------------------------------------------------
    if (PIPE != 0) begin : g_pipe
        // Level k consumes src_* and registers into stg_*; stage k pairs words with esel[k].
        word_t           src_data [SELW][NUM_IN];
        logic [SELW-1:0] src_ch   [SELW];
        logic            src_vld  [SELW];
        word_t           stg_data [SELW][HALF];
        logic [SELW-1:0] stg_ch   [SELW];
        logic            stg_vld  [SELW];

        always_comb begin
            for (int k = 0; k < SELW; k++) begin
                for (int i = 0; i < NUM_IN; i++) begin
                    src_data[k][i] = '0;
                end
                src_ch[k]  = '0;
                src_vld[k] = 1'b0;
            end
            for (int i = 0; i < NUM_IN; i++) begin
                src_data[0][i] = din[i*WIDTH +: WIDTH];
            end
            src_ch[0]  = esel;
            src_vld[0] = in_valid;
            for (int k = 1; k < SELW; k++) begin
                for (int j = 0; j < HALF; j++) begin
                    src_data[k][j] = stg_data[k-1][j];
                end
                src_ch[k]  = stg_ch[k-1];
                src_vld[k] = stg_vld[k-1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < SELW; k++) begin
                    for (int j = 0; j < HALF; j++) begin
                        stg_data[k][j] <= '0;
                    end
                    stg_ch[k]  <= '0;
                    stg_vld[k] <= 1'b0;
                end
            end else begin
                for (int k = 0; k < SELW; k++) begin
                    stg_vld[k] <= src_vld[k];
                    // Data and index only move with a valid sample; bubbles leave them held.
                    if (src_vld[k]) begin
                        stg_ch[k] <= src_ch[k];
                        for (int j = 0; j < HALF; j++) begin
                            stg_data[k][j] <= src_ch[k][k] ? src_data[k][2*j+1]
                                                           : src_data[k][2*j];
                        end
                    end
                end
            end
        end

        assign out       = stg_data[SELW-1][0];
        assign out_ch    = stg_ch[SELW-1];
        assign out_valid = stg_vld[SELW-1];
    end else begin : g_comb
        word_t           tree_out;
        word_t           out_q;
        logic [SELW-1:0] ch_q;
        logic            vld_q;

        // Reduce in place: level k writes word j from words 2j and 2j+1 of the level below.
        always_comb begin
            word_t t [NUM_IN];
            for (int i = 0; i < NUM_IN; i++) begin
                t[i] = din[i*WIDTH +: WIDTH];
            end
            for (int k = 0; k < SELW; k++) begin
                for (int j = 0; j < (NUM_IN >> (k + 1)); j++) begin
                    t[j] = esel[k] ? t[2*j+1] : t[2*j];
                end
            end
            tree_out = t[0];
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                out_q <= '0;
                ch_q  <= '0;
                vld_q <= 1'b0;
            end else begin
                vld_q <= in_valid;
                if (in_valid) begin
                    out_q <= tree_out;
                    ch_q  <= esel;
                end
            end
        end

        assign out       = out_q;
        assign out_ch    = ch_q;
        assign out_valid = vld_q;
    end

endmodule

// File: tb/tb_muxn_pipe_scan.sv
// Scoreboard bench for muxn_pipe_scan: a pipelined (PIPE=1) and a combinational (PIPE=0)
// instance share stimulus; each has its own expected queue carrying data, channel and
// the cycle on which the item must appear.
module tb_muxn_pipe_scan;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic [1:0]  sel = '0;
    logic        mode = 1'b0;
    logic        in_valid = 1'b0;

    logic [7:0] o_p1, o_p0;
    logic       v_p1, v_p0;
    logic [1:0] ch_p1, ch_p0;
    logic       w_p1, w_p0;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    int wrap_t = -1000;

    typedef struct {
        logic [7:0] data;
        logic [1:0] ch;
        int         due;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [7:0] last_out [2];
    logic [1:0] last_ch  [2];

    localparam logic [31:0] DA = 32'hD4C3B2A1;
    localparam logic [31:0] DB = 32'h5A3CF00F;

    muxn_pipe_scan #(.WIDTH(8), .NUM_IN(4), .PIPE(1), .DWELL(2)) u_p1 (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .in_valid(in_valid),
        .out(o_p1), .out_valid(v_p1), .out_ch(ch_p1), .scan_wrap(w_p1)
    );

    muxn_pipe_scan #(.WIDTH(8), .NUM_IN(4), .PIPE(0), .DWELL(2)) u_p0 (
        .clk(clk), .rst(rst), .din(din), .sel(sel), .mode(mode), .in_valid(in_valid),
        .out(o_p0), .out_valid(v_p0), .out_ch(ch_p0), .scan_wrap(w_p0)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic mon(input int idx, input logic [7:0] o, input logic v, input logic [1:0] ch);
        exp_t e;
        logic have;
        have = 1'b0;
        if (idx == 0) begin
            if (q0.size() > 0) begin
                e = q0[0];
                have = 1'b1;
            end
        end else begin
            if (q1.size() > 0) begin
                e = q1[0];
                have = 1'b1;
            end
        end
        if (v) begin
            if (!have) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid[%0d]: got out=%0h ch=%0d, expected no item (cycle %0d)",
                         idx, o, ch, cyc);
            end else begin
                if (idx == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
                chk($sformatf("data[%0d]", idx), 32'(o), 32'(e.data));
                chk($sformatf("ch[%0d]", idx), 32'(ch), 32'(e.ch));
                chk($sformatf("latency[%0d]", idx), cyc, e.due);
                last_out[idx] = e.data;
                last_ch[idx]  = e.ch;
            end
        end else begin
            chk($sformatf("hold[%0d]", idx), {22'd0, o, ch}, {22'd0, last_out[idx], last_ch[idx]});
            if (have && e.due <= cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_item[%0d]: got no valid, expected data=%0h ch=%0d (cycle %0d)",
                         idx, e.data, e.ch, cyc);
                if (idx == 0) void'(q0.pop_front());
                else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic exp_w;
            exp_w = (cyc == wrap_t + 8) || (cyc == wrap_t + 16);
            mon(0, o_p1, v_p1, ch_p1);
            mon(1, o_p0, v_p0, ch_p0);
            chk("scan_wrap_p1", 32'(w_p1), 32'(exp_w));
            chk("scan_wrap_p0", 32'(w_p0), 32'(exp_w));
        end
    end

    task automatic drive(input logic m, input logic [1:0] s, input logic v,
                         input logic [31:0] d, input logic [1:0] ech);
        exp_t e;
        mode     = m;
        sel      = s;
        in_valid = v;
        din      = d;
        if (v) begin
            e.data = d[ech*8 +: 8];
            e.ch   = ech;
            e.due  = cyc + 2;
            q0.push_back(e);
            e.due  = cyc + 1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'd0, 1'b0, DA, 2'd0);
    endtask

    task automatic manual_pass();
        for (int i = 0; i < 4; i++) drive(1'b0, 2'(i), 1'b1, DA, 2'(i));
        drive(1'b0, 2'd3, 1'b1, DB, 2'd3);
        drive(1'b0, 2'd0, 1'b1, DB, 2'd0);
        drive(1'b0, 2'd2, 1'b1, DB, 2'd2);
        drive(1'b0, 2'd1, 1'b1, DB, 2'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_p1"}, {20'd0, v_p1, w_p1, o_p1, ch_p1}, 32'd0);
        chk({name, "_p0"}, {20'd0, v_p0, w_p0, o_p0, ch_p0}, 32'd0);
    endtask

    initial begin
        logic [1:0] scan_seq [16];
        scan_seq = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3,
                     2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        for (int i = 0; i < 2; i++) begin
            last_out[i] = '0;
            last_ch[i]  = '0;
        end

        // Reset held across edges, then released with the inputs idle.
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;
        idle(5);

        // Manual selection, back to back.
        manual_pass();

        // Single valid sample followed by bubbles.
        drive(1'b0, 2'd3, 1'b1, DA, 2'd3);
        idle(3);
        idle(2);

        // Scan with DWELL=2; sel is deliberately non-zero and must be ignored.
        wrap_t = cyc;
        for (int i = 0; i < 16; i++) drive(1'b1, 2'd3, 1'b1, DA, scan_seq[i]);
        idle(3);

        // Leave scan while on channel 2, then re-enter.
        drive(1'b1, 2'd3, 1'b1, DB, 2'd0);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd0);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd1);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd1);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd2);
        drive(1'b0, 2'd1, 1'b1, DB, 2'd1);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd0);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd0);
        drive(1'b1, 2'd3, 1'b1, DB, 2'd1);
        idle(3);

        // Reset pulse mid-cycle with items still in flight.
        drive(1'b0, 2'd1, 1'b1, DA, 2'd1);
        drive(1'b0, 2'd2, 1'b1, DA, 2'd2);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 2; i++) begin
            last_out[i] = '0;
            last_ch[i]  = '0;
        end
        #1;
        chk_reset_outputs("async_reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(5);

        // Manual pass again after reset; both latencies are checked per item.
        manual_pass();
        idle(4);

        chk("queue_empty_p1", q0.size(), 32'd0);
        chk("queue_empty_p0", q1.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
